controller_sequencer: RTL and testbench

//  SAP-1 control unit: 6-state one-hot ring counter (T1..T6) plus instruction decoder driving
//  the control word. Sits directly upstream of bus_controller: supplies its bus enables
//  (ep/ce_n/ei_n/ea/eu) and the load/increment strobes for PC, MAR, IR, A, B and OUT.

---
 rtl/sap1_pkg.sv | 20 ++
 rtl/t_ring_counter.sv | 32 +++
 rtl/controller_sequencer.sv | 112 +++++++++++
 tb/tb_controller_sequencer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 definitions: opcode encodings, one-hot T-state codes and widths.
package sap1_pkg;
   localparam int OPCODE_W = 4;
   localparam int T_STATES = 6;

   typedef enum logic [T_STATES-1:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   localparam logic [OPCODE_W-1:0] OP_LDA = 4'h0;
   localparam logic [OPCODE_W-1:0] OP_ADD = 4'h1;
   localparam logic [OPCODE_W-1:0] OP_SUB = 4'h2;
   localparam logic [OPCODE_W-1:0] OP_OUT = 4'hE;
   localparam logic [OPCODE_W-1:0] OP_HLT = 4'hF;
endpackage

// File: rtl/t_ring_counter.sv
// One-hot T1..T6 ring; rotates on adv, returns to T1 on synchronous active-low reset.
module t_ring_counter
   import sap1_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       adv,
   output logic [5:0] ring
);
   t_state_e state, state_nxt;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= T1;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      if (adv) begin
         case (state)
            T1:      state_nxt = T2;
            T2:      state_nxt = T3;
            T3:      state_nxt = T4;
            T4:      state_nxt = T5;
            T5:      state_nxt = T6;
            default: state_nxt = T1;
         endcase
      end
   end

   assign ring = state;
endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 control unit: T-state ring plus opcode decode producing bus enables and
// load/increment strobes; HLT freezes the machine until reset.
module controller_sequencer #(
   parameter int OPCODE_W = 4,
   parameter int T_STATES = 6
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                run_i,
   input  logic                step_i,
   input  logic [OPCODE_W-1:0] opcode_i,
   output logic [T_STATES-1:0] t_state_o,
   output logic                hlt_o,
   output logic                ep_o,
   output logic                ce_n_o,
   output logic                ei_n_o,
   output logic                ea_o,
   output logic                eu_o,
   output logic                su_o,
   output logic                cp_o,
   output logic                lm_n_o,
   output logic                li_n_o,
   output logic                la_n_o,
   output logic                lb_n_o,
   output logic                lo_n_o
);
   import sap1_pkg::*;

   logic       step_q, halt;
   logic [5:0] ring;
   logic       step_rise, advance, hlt_t4, active;
   logic       mem_op, alu_op;
   logic       ep, ce, ei, ea, eu, su, cp, lm, li, la, lb, lo;

   assign step_rise = step_i & ~step_q;
   assign advance   = ~halt & (run_i | step_rise);
   assign hlt_t4    = ring[3] & (opcode_i == OP_HLT);
   assign active    = rst_n_i & ~halt;

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         step_q <= 1'b0;
         halt   <= 1'b0;
      end else begin
         step_q <= step_i;
         if (advance && hlt_t4) halt <= 1'b1;
      end
   end

   // HLT parks the ring at T4 instead of rotating
   t_ring_counter u_ring (
      .clk   (clk_i),
      .rst_n (rst_n_i),
      .adv   (advance & ~hlt_t4),
      .ring  (ring)
   );

   assign mem_op = (opcode_i == OP_LDA) || (opcode_i == OP_ADD) || (opcode_i == OP_SUB);
   assign alu_op = (opcode_i == OP_ADD) || (opcode_i == OP_SUB);

   // Enables follow the T-state; strobes are raw here and gated by advance below
   always_comb begin
      ep = 1'b0; ce = 1'b0; ei = 1'b0; ea = 1'b0; eu = 1'b0; su = 1'b0;
      cp = 1'b0; lm = 1'b0; li = 1'b0; la = 1'b0; lb = 1'b0; lo = 1'b0;
      if (active) begin
         case (ring)
            T1: begin ep = 1'b1; lm = 1'b1; end
            T2: cp = 1'b1;
            T3: begin ce = 1'b1; li = 1'b1; end
            T4: begin
               if (mem_op) begin
                  ei = 1'b1; lm = 1'b1;
               end else if (opcode_i == OP_OUT) begin
                  ea = 1'b1; lo = 1'b1;
               end
            end
            T5: begin
               if (mem_op) begin
                  ce = 1'b1;
                  la = (opcode_i == OP_LDA);
                  lb = alu_op;
               end
            end
            T6: begin
               if (alu_op) begin
                  eu = 1'b1; la = 1'b1;
                  su = (opcode_i == OP_SUB);
               end
            end
            default: ;
         endcase
      end
   end

   assign t_state_o = rst_n_i ? ring : T1;
   assign hlt_o     = rst_n_i & halt;
   assign ep_o      = ep;
   assign ce_n_o    = ~ce;
   assign ei_n_o    = ~ei;
   assign ea_o      = ea;
   assign eu_o      = eu;
   assign su_o      = su;
   assign cp_o      = cp & advance;
   assign lm_n_o    = ~(lm & advance);
   assign li_n_o    = ~(li & advance);
   assign la_n_o    = ~(la & advance);
   assign lb_n_o    = ~(lb & advance);
   assign lo_n_o    = ~(lo & advance);

   bus_excl_a : assert property (@(posedge clk_i)
      $onehot0({ep_o, ~ce_n_o, ~ei_n_o, ea_o, eu_o}));
endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: a behavioural model predicts the control
// word each cycle, queues it, and the negedge sample is compared against it.
module tb_controller_sequencer;
   logic       clk_i = 1'b0;
   logic       rst_n_i = 1'b0, run_i = 1'b1, step_i = 1'b0;
   logic [3:0] opcode_i = 4'h0;
   logic [5:0] t_state_o;
   logic       hlt_o, ep_o, ce_n_o, ei_n_o, ea_o, eu_o, su_o;
   logic       cp_o, lm_n_o, li_n_o, la_n_o, lb_n_o, lo_n_o;

   controller_sequencer dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i), .run_i(run_i), .step_i(step_i), .opcode_i(opcode_i),
      .t_state_o(t_state_o), .hlt_o(hlt_o), .ep_o(ep_o), .ce_n_o(ce_n_o), .ei_n_o(ei_n_o),
      .ea_o(ea_o), .eu_o(eu_o), .su_o(su_o), .cp_o(cp_o), .lm_n_o(lm_n_o), .li_n_o(li_n_o),
      .la_n_o(la_n_o), .lb_n_o(lb_n_o), .lo_n_o(lo_n_o)
   );

   always #5 clk_i = ~clk_i;

   int n_tests = 0, n_fail = 0;
   logic [18:0] exp_q[$];
   logic [18:0] dut_word;
   assign dut_word = {t_state_o, hlt_o, ep_o, ce_n_o, ei_n_o, ea_o, eu_o, su_o,
                      cp_o, lm_n_o, li_n_o, la_n_o, lb_n_o, lo_n_o};

   // model state
   int   m_t = 0;
   logic m_halt = 1'b0, m_stepq = 1'b0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   function automatic logic [18:0] model_out(input logic r, input logic ru, input logic st,
                                              input logic [3:0] op);
      logic adv, mem, alu;
      logic ep, ce, ei, ea, eu, su, cp, lm, li, la, lb, lo;
      logic [5:0] t;
      ep = 0; ce = 0; ei = 0; ea = 0; eu = 0; su = 0;
      cp = 0; lm = 0; li = 0; la = 0; lb = 0; lo = 0;
      adv = ru || (st && !m_stepq);
      mem = (op == 4'h0) || (op == 4'h1) || (op == 4'h2);
      alu = (op == 4'h1) || (op == 4'h2);
      if (r && !m_halt) begin
         case (m_t)
            0: begin ep = 1; lm = adv; end
            1: cp = adv;
            2: begin ce = 1; li = adv; end
            3: if (mem) begin ei = 1; lm = adv; end
               else if (op == 4'hE) begin ea = 1; lo = adv; end
            4: if (mem) begin ce = 1; la = adv && (op == 4'h0); lb = adv && alu; end
            5: if (alu) begin eu = 1; la = adv; su = (op == 4'h2); end
            default: ;
         endcase
      end
      t = r ? 6'(1 << m_t) : 6'b000001;
      return {t, r && m_halt, ep, !ce, !ei, ea, eu, su, cp, !lm, !li, !la, !lb, !lo};
   endfunction

   task automatic model_step(input logic r, input logic ru, input logic st, input logic [3:0] op);
      logic adv;
      if (!r) begin
         m_t = 0; m_halt = 0; m_stepq = 0;
      end else begin
         adv = !m_halt && (ru || (st && !m_stepq));
         m_stepq = st;
         if (adv) begin
            if (m_t == 3 && op == 4'hF) m_halt = 1;
            else m_t = (m_t + 1) % 6;
         end
      end
   endtask

   // one clock: drive after the edge, queue the prediction, compare at negedge
   task automatic cyc(input logic r, input logic ru, input logic st, input logic [3:0] op);
      logic [4:0] bus;
      @(posedge clk_i); #1;
      rst_n_i = r; run_i = ru; step_i = st; opcode_i = op;
      exp_q.push_back(model_out(r, ru, st, op));
      @(negedge clk_i);
      chk("cw", 32'(dut_word), 32'(exp_q.pop_front()));
      bus = {ep_o, ~ce_n_o, ~ei_n_o, ea_o, eu_o};
      chk("excl", 32'($countones(bus) <= 1), 32'd1);
      model_step(r, ru, st, op);
   endtask

   initial begin
      int cp_cnt;
      logic [3:0] op;
      // reset, two clocks
      cyc(0, 1, 0, 4'h0);
      cyc(0, 1, 0, 4'h0);
      chk("rst_t", 32'(t_state_o), 32'h01);
      chk("rst_hlt", 32'(hlt_o), 32'h0);
      chk("rst_n_all", 32'({ce_n_o, ei_n_o, lm_n_o, li_n_o, la_n_o, lb_n_o, lo_n_o}), 32'h7f);

      // free-run LDA, SUB, ADD
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 4'h0);
         if (i == 4) chk("lda_t5_la", 32'({ce_n_o, la_n_o}), 32'h0);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 4'h2);
         if (i == 0) chk("wrap_t1", 32'(t_state_o), 32'h01);
         if (i == 5) chk("sub_t6", 32'({eu_o, la_n_o, su_o}), 32'b101);
      end
      for (int i = 0; i < 6; i++) begin
         cyc(1, 1, 0, 4'h1);
         if (i == 4) chk("add_t5_lb", 32'(lb_n_o), 32'h0);
         if (i == 5) chk("add_t6", 32'({eu_o, la_n_o, su_o}), 32'b100);
      end

      // step mode: dwell in T1, one step to T2, then hold step high 5 clks
      for (int i = 0; i < 3; i++) begin
         cyc(1, 0, 0, 4'h0);
         chk("t1_dwell_ep", 32'({ep_o, lm_n_o}), 32'b11);
      end
      cyc(1, 0, 1, 4'h0);
      cyc(1, 0, 0, 4'h0);
      chk("step_t2", 32'(t_state_o), 32'h02);
      cp_cnt = 0;
      for (int i = 0; i < 5; i++) begin
         cyc(1, 0, 1, 4'h0);
         cp_cnt += int'(cp_o);
      end
      chk("cp_once", 32'(cp_cnt), 32'd1);
      cyc(1, 0, 0, 4'h0);
      chk("hold_t3", 32'(t_state_o), 32'h04);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 1, 4'h0);
         cyc(1, 0, 0, 4'h0);
      end
      chk("step_wrap", 32'(t_state_o), 32'h01);

      // HLT
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 4'hF);
      for (int i = 0; i < 20; i++) begin
         cyc(1, 1'($urandom), 1'($urandom), 4'($urandom));
         chk("halt_frozen", 32'({t_state_o, hlt_o}), 32'({6'b001000, 1'b1}));
      end
      cyc(0, 1, 0, 4'h0);
      cyc(1, 1, 0, 4'h0);
      chk("halt_exit", 32'({t_state_o, hlt_o}), 32'({6'b000001, 1'b0}));

      // reset during T5 of ADD
      for (int i = 0; i < 4; i++) cyc(1, 1, 0, 4'h1);
      cyc(0, 1, 0, 4'h1);
      chk("rst_t5_lb", 32'(lb_n_o), 32'h1);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 1, 0, 4'h1);
         if (i == 0) chk("rst_t5_t1", 32'(t_state_o), 32'h01);
         chk("rst_t5_nolb", 32'(lb_n_o), 32'h1);
      end

      // random soak
      for (int i = 0; i < 1000; i++) begin
         case ($urandom_range(0, 5))
            0: op = 4'h0;
            1: op = 4'h1;
            2: op = 4'h2;
            3: op = 4'hE;
            4: op = 4'hF;
            default: op = 4'($urandom);
         endcase
         cyc(1'($urandom_range(0, 39) != 0), 1'($urandom), 1'($urandom), op);
      end

      chk("q_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
